map_column_streamer: RTL and testbench
======================================

Name: map_column_streamer

Overview:
- Producer end of the wall shift-in interface: supplies one COL_H-bit wall column per request to the game datapath's physics step.
- Replaces the hard-coded alternating column patterns with a map held in an external synchronous ROM.
- The ROM stores run-length-encoded entries. The block fetches each entry, expands it into a column bit-vector, and serves that column for "run" consecutive requests.

Parameters:
- COL_H, 100, column height in bits (rows).
- ADDR_W, 8, ROM address width.
- LOOP, 1, 1 = restart from address 0 at end of map; 0 = stop and emit empty columns.

Ports:
- clk  input  1  system clock.
- resetn  input  1  reset. Synchronous, active-low.
- start  input  1  synchronous restart of the map at address 0. resetn has priority over start.
- col_req  input  1  request for the next column. Accepted only in a cycle where ready=1.
- ready  output  1  a column can be accepted this cycle.
- col_valid  output  1  one-cycle pulse, the cycle after an accepted request.
- col_data  output  COL_H  delivered column. Bit j=1 means wall at row j. Held between deliveries.
- map_done  output  1  high while in DONE.
- rom_addr  output  ADDR_W  ROM address.
- rom_data  input  24  ROM word. Valid the cycle after rom_addr is presented (1-cycle latency).
  - [23:16] run length in columns; 0 = end-of-map marker.
  - [15:8] bottom wall height.
  - [7:0] top wall height.

Behaviour:
- Reset values: ready=0, col_valid=0, col_data=0, map_done=0, rom_addr=0, state=FETCH.
- States: FETCH, LATCH, READY, DONE.
- FETCH:
  - rom_addr presents the current address; ready=0.
  - Next state is LATCH.
- LATCH: captures rom_data.
  - run=0, LOOP=1, addr≠0: addr←0 -> FETCH.
  - run=0, LOOP=1, addr=0 (empty map): -> DONE.
  - run=0, LOOP=0: -> DONE.
  - run≠0: remaining←run; build the column into an internal register; -> READY.
- Column build:
  - bit j = (j < bot) | (j ≥ COL_H − top).
  - bot and top are each clamped to COL_H before comparison; arithmetic is at least 8 bits wide.
  - bot+top ≥ COL_H gives an all-ones column; bot=top=0 gives an all-zero column.
- READY: ready=1. On col_req:
  - col_data←column; col_valid=1 in the next cycle; remaining←remaining−1.
  - If remaining was 1: addr←addr+1, next state FETCH (ready=0 from the next cycle).
  - Otherwise stay in READY; back-to-back requests on consecutive cycles are all accepted.
- Address wrap: an increment from 2^ADDR_W−1 is treated as an end-of-map marker with no ROM read.
  - LOOP=1: addr←0 -> FETCH.
  - LOOP=0: -> DONE.
- DONE:
  - ready=1, map_done=1.
  - Each col_req delivers an all-zero column with a col_valid pulse.
  - Stays in DONE until start or reset.
- Gap between runs: 2 cycles of ready=0 (FETCH, LATCH). col_req while ready=0 is ignored, not queued.
- start in any state (including mid-run or on the same cycle as col_req):
  - addr←0, state←FETCH, map_done←0, col_valid←0, remaining←0.
  - col_data is held; the concurrent col_req is dropped.
- Reset mid-operation: every output returns to its reset value on the next edge, regardless of state.
- col_valid is never high for two cycles from a single request. col_data changes only on a col_valid cycle, or on reset.

Test Plan:
1. ROM[0]={3,20,0}, ROM[1]={0,0,0}, LOOP=0; four col_req pulses:
   - 1st–3rd: col_data=bits 0..19 set (0x00000_..._FFFFF).
   - 4th: col_data=0 with map_done=1.
   - Check ready=0 for exactly 2 cycles after reset and again after the 3rd delivery.
2. ROM[0]={1,0,20}, ROM[1]={2,40,40}, ROM[2]={0,..}, LOOP=1; six requests:
   - Sequence: top20 only; bits 0–39 and 60–99 (twice); then top20 again after the loop.
   - map_done never asserts.
3. Clamp/overlap: ROM[0]={1,70,50} -> all-ones column. ROM[0]={1,200,0} -> all-ones column. ROM[0]={1,0,0} -> all-zero column.
4. col_req held high continuously over ROM[0]={2,10,0}, ROM[1]={1,0,10}:
   - Exactly 3 col_valid pulses, with a 2-cycle gap between the 2nd and 3rd.
   - Requests during ready=0 produce no pulse.
5. start asserted mid-run (remaining=2) together with col_req:
   - No col_valid that cycle.
   - rom_addr=0 next cycle; the first subsequent delivery is ROM[0]'s column.
   - With LOOP=0 from DONE, start clears map_done.
6. Empty map: ROM[0]={0,..} with LOOP=1 -> DONE, no address-0 refetch loop, map_done=1. Then resetn=0 for 1 cycle -> all outputs at reset values.

Source files
------------

// File: rtl/map_column_streamer.sv
// map_column_streamer: expands run-length-encoded wall columns from a synchronous ROM into per-request columns.
module map_column_streamer #(
  parameter int COL_H = 100,
  parameter int ADDR_W = 8,
  parameter bit LOOP = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              col_req,
  output logic              ready,
  output logic              col_valid,
  output logic [COL_H-1:0]  col_data,
  output logic              map_done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [23:0]       rom_data
);
  typedef enum logic [1:0] {FETCH, LATCH, READY, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0] rem, rem_n;
  logic [COL_H-1:0] column, column_n, data_n, built;
  logic valid_n;
  logic [31:0] bot, top;
  assign ready = state inside {READY, DONE};
  assign map_done = state == DONE;
  always_comb begin
    bot = {24'd0, rom_data[15:8]};
    top = {24'd0, rom_data[7:0]};
    bot = (bot > COL_H) ? COL_H : bot;
    top = (top > COL_H) ? COL_H : top;
    built = '0;
    for (int j = 0; j < COL_H; j++) built[j] = (j < bot) || (j >= COL_H - top);
  end
  always_comb begin
    state_n = state;
    addr_n = rom_addr;
    rem_n = rem;
    column_n = column;
    data_n = col_data;
    valid_n = 1'b0;
    case (state)
      FETCH: state_n = LATCH;
      LATCH:
        if (rom_data[23:16] == 8'd0) begin
          state_n = (LOOP && rom_addr != '0) ? FETCH : DONE;
          addr_n = '0;
        end else begin
          rem_n = rom_data[23:16];
          column_n = built;
          state_n = READY;
        end
      READY:
        if (col_req) begin
          data_n = column;
          valid_n = 1'b1;
          rem_n = rem - 8'd1;
          if (rem == 8'd1) begin
            // an increment past the last address wraps to 0 and acts as an end-of-map marker
            addr_n = rom_addr + 1'b1;
            state_n = (&rom_addr && !LOOP) ? DONE : FETCH;
          end
        end
      DONE:
        if (col_req) begin
          data_n = '0;
          valid_n = 1'b1;
        end
    endcase
    if (start) begin
      state_n = FETCH;
      addr_n = '0;
      rem_n = '0;
      valid_n = 1'b0;
      data_n = col_data;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= FETCH;
      rom_addr <= '0;
      rem <= '0;
      column <= '0;
      col_data <= '0;
      col_valid <= 1'b0;
    end else begin
      state <= state_n;
      rom_addr <= addr_n;
      rem <= rem_n;
      column <= column_n;
      col_data <= data_n;
      col_valid <= valid_n;
    end
  end
endmodule

// File: tb/tb_map_column_streamer.sv
// tb_map_column_streamer: scoreboard bench driving a LOOP=0 (index 0) and a LOOP=1 (index 1) instance from one ROM image.
module tb_map_column_streamer;
  localparam logic [99:0] ONES = '1;
  localparam logic [99:0] B20 = ONES >> 80;
  localparam logic [99:0] T20 = ONES << 80;
  localparam logic [99:0] MID = (ONES >> 60) | (ONES << 60);
  localparam logic [99:0] B10 = ONES >> 90;
  localparam logic [99:0] T10 = ONES << 90;
  localparam logic [99:0] B5 = ONES >> 95;
  localparam logic [99:0] T5 = ONES << 95;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [1:0] st = '0, cr = '0, rdy, vld, dn;
  logic [99:0] cd [2];
  logic [7:0] ra [2];
  logic [23:0] rd [2];
  logic [23:0] rom [256];
  logic [100:0] q0 [$], q1 [$];
  logic [100:0] mon_e;
  logic [12:0] pat;
  logic all_done;
  int checks = 0, failures = 0, mchecks = 0, mfails = 0;

  always #5 clk = ~clk;

  map_column_streamer #(.COL_H(100), .ADDR_W(8), .LOOP(0)) dut0 (
    .clk(clk), .resetn(resetn), .start(st[0]), .col_req(cr[0]), .ready(rdy[0]),
    .col_valid(vld[0]), .col_data(cd[0]), .map_done(dn[0]), .rom_addr(ra[0]), .rom_data(rd[0]));
  map_column_streamer #(.COL_H(100), .ADDR_W(8), .LOOP(1)) dut1 (
    .clk(clk), .resetn(resetn), .start(st[1]), .col_req(cr[1]), .ready(rdy[1]),
    .col_valid(vld[1]), .col_data(cd[1]), .map_done(dn[1]), .rom_addr(ra[1]), .rom_data(rd[1]));

  always_ff @(posedge clk) begin
    rd[0] <= rom[ra[0]];
    rd[1] <= rom[ra[1]];
  end

  always @(negedge clk)
    for (int k = 0; k < 2; k++)
      if (vld[k]) begin
        mchecks++;
        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
          mfails++;
          $display("FAIL unexpected_valid%0d got done=%0b col=%0h, wanted no delivery", k, dn[k], cd[k]);
        end else begin
          mon_e = (k == 0) ? q0.pop_front() : q1.pop_front();
          if ({dn[k], cd[k]} !== mon_e) begin
            mfails++;
            $display("FAIL delivery%0d got done=%0b col=%0h, wanted done=%0b col=%0h",
                     k, dn[k], cd[k], mon_e[100], mon_e[99:0]);
          end
        end
      end

  function automatic logic [23:0] w(input logic [7:0] run, input logic [7:0] bot, input logic [7:0] top);
    return {run, bot, top};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %0h wanted %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [100:0] e);
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic rst_all();
    @(negedge clk);
    resetn = 1'b0;
    cr = '0;
    st = '0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic req(input int k, input logic [100:0] e);
    int n = 0;
    while (!rdy[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[k]) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout%0d got ready=0 after %0d cycles, wanted ready=1", k, n);
    end else begin
      push(k, e);
      cr[k] = 1'b1;
      @(negedge clk);
      cr[k] = 1'b0;
    end
  endtask

  task automatic gap(input int k, input int exp_n, input string nm);
    int n = 0;
    while (!rdy[k] && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk(nm, 128'(n), 128'(exp_n));
  endtask

  task automatic check_rst(input int k, input string nm);
    chk(nm, 128'({rdy[k], vld[k], dn[k], ra[k], cd[k]}), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish, wanted finish before time limit");
    $fatal(1);
  end

  initial begin
    clear_rom();
    repeat (2) @(negedge clk);
    check_rst(0, "reset_state0");
    check_rst(1, "reset_state1");
    // single run then end marker, stop at end
    rom[0] = w(3, 20, 0);
    rst_all();
    gap(0, 2, "gap_after_reset");
    repeat (3) req(0, {1'b0, B20});
    gap(0, 2, "gap_after_run");
    req(0, {1'b1, 100'd0});
    chk("done_after_end", 128'(dn[0]), 128'(1));
    // looping map
    clear_rom();
    rom[0] = w(1, 0, 20);
    rom[1] = w(2, 40, 40);
    rst_all();
    req(1, {1'b0, T20});
    req(1, {1'b0, MID});
    req(1, {1'b0, MID});
    req(1, {1'b0, T20});
    req(1, {1'b0, MID});
    req(1, {1'b0, MID});
    chk("loop_no_done", 128'(dn[1]), 128'(0));
    // clamp and overlap
    clear_rom();
    rom[0] = w(1, 70, 50);
    rst_all();
    req(1, {1'b0, ONES});
    rom[0] = w(1, 200, 0);
    rst_all();
    req(1, {1'b0, ONES});
    rom[0] = w(1, 0, 0);
    rst_all();
    req(1, {1'b0, 100'd0});
    // col_req held high across two runs
    clear_rom();
    rom[0] = w(2, 10, 0);
    rom[1] = w(1, 0, 10);
    push(1, {1'b0, B10});
    push(1, {1'b0, B10});
    push(1, {1'b0, T10});
    rst_all();
    cr[1] = 1'b1;
    for (int i = 0; i < 13; i++) begin
      pat[i] = vld[1];
      if (i == 9) cr[1] = 1'b0;
      @(negedge clk);
    end
    chk("held_req_pattern", 128'(pat), 128'(13'b0000010011000));
    // start mid-run with a concurrent request
    clear_rom();
    rom[0] = w(1, 0, 5);
    rom[1] = w(3, 5, 0);
    rst_all();
    req(0, {1'b0, T5});
    req(0, {1'b0, B5});
    cr[0] = 1'b1;
    st[0] = 1'b1;
    @(negedge clk);
    cr[0] = 1'b0;
    st[0] = 1'b0;
    chk("start_no_valid", 128'(vld[0]), 128'(0));
    chk("start_addr", 128'(ra[0]), 128'(0));
    chk("start_holds_data", 128'(cd[0]), 128'(B5));
    req(0, {1'b0, T5});
    repeat (3) req(0, {1'b0, B5});
    req(0, {1'b1, 100'd0});
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    chk("start_clears_done", 128'(dn[0]), 128'(0));
    // empty map with looping enabled
    clear_rom();
    rst_all();
    repeat (4) @(negedge clk);
    all_done = 1'b1;
    for (int i = 0; i < 6; i++) begin
      all_done &= dn[1] & rdy[1] & (ra[1] == 8'd0);
      @(negedge clk);
    end
    chk("empty_map_done", 128'(all_done), 128'(1));
    req(1, {1'b1, 100'd0});
    resetn = 1'b0;
    @(negedge clk);
    check_rst(1, "reset_from_done");
    resetn = 1'b1;
    // reset mid-run clears held data
    rom[0] = w(2, 10, 0);
    rst_all();
    req(0, {1'b0, B10});
    req(1, {1'b0, B10});
    resetn = 1'b0;
    @(negedge clk);
    check_rst(0, "reset_mid_run0");
    check_rst(1, "reset_mid_run1");
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    chk("pending_deliveries", 128'(q0.size() + q1.size()), 128'(0));
    checks += mchecks;
    failures += mfails;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
